// File: rtl/queue_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : queue_controller                                              |
// | Brief    : Initiator-side controller for the 8-entry byte queue. Takes   |
// |            producer bytes over valid/ready, issues enqueue pulses with   |
// |            bounded retry on nack, and services latched read requests     |
// |            with dequeue pulses and a one-cycle rd_valid strobe.          |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module queue_controller #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int MAX_RETRY = 4
) (
    input  logic                         clk_10khz,
    input  logic                         reset,
    input  logic                         wr_valid,
    input  logic [DATA_W-1:0]            wr_data,
    output logic                         wr_ready,
    output logic                         wr_done,
    output logic                         wr_err,
    input  logic                         rd_req,
    output logic                         rd_valid,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         rd_empty_err,
    output logic [DATA_W-1:0]            q_data,
    output logic                         q_enqueue,
    output logic                         q_dequeue,
    input  logic                         q_ack,
    input  logic [$clog2(DEPTH+1)-1:0]   q_len,
    input  logic [DATA_W-1:0]            q_data_out,
    output logic                         busy
);

    localparam logic [2:0] c_S_IDLE     = 3'd0;
    localparam logic [2:0] c_S_ENQ      = 3'd1;
    localparam logic [2:0] c_S_ENQ_WAIT = 3'd2;
    localparam logic [2:0] c_S_DEQ      = 3'd3;
    localparam logic [2:0] c_S_DEQ_WAIT = 3'd4;

    // One extra bit so the counter can never wrap before the drop decision.
    localparam int                   c_RETRY_W    = $clog2(MAX_RETRY) + 1;
    localparam logic [c_RETRY_W-1:0] c_RETRY_LAST = c_RETRY_W'(MAX_RETRY - 1);

    logic [2:0]           r_state;
    logic [2:0]           w_next_state;
    logic                 r_rd_pend;
    logic                 r_wr_held;
    logic [c_RETRY_W-1:0] r_retry_cnt;
    logic [DATA_W-1:0]    r_q_data;
    logic [DATA_W-1:0]    r_rd_data;
    logic                 r_wr_done;
    logic                 r_wr_err;
    logic                 r_rd_valid;
    logic                 r_rd_empty_err;

    logic w_q_nonempty;
    logic w_capture;
    logic w_ack_done;
    logic w_drop;
    logic w_empty_err;
    logic w_retry_inc;
    logic w_rd_done;

    assign w_q_nonempty = (q_len != '0);

    // State register.
    always_ff @(posedge clk_10khz) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and per-cycle control decode; reads take priority over new writes.
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        w_ack_done   = 1'b0;
        w_drop       = 1'b0;
        w_empty_err  = 1'b0;
        w_retry_inc  = 1'b0;
        w_rd_done    = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (r_rd_pend && w_q_nonempty) begin
                    w_next_state = c_S_DEQ;
                end else if (r_rd_pend) begin
                    w_empty_err = 1'b1;
                end else if (wr_valid && wr_ready) begin
                    w_capture    = 1'b1;
                    w_next_state = c_S_ENQ;
                end
            end
            c_S_ENQ: begin
                w_next_state = c_S_ENQ_WAIT;
            end
            c_S_ENQ_WAIT: begin
                if (q_ack) begin
                    w_ack_done   = 1'b1;
                    w_next_state = c_S_IDLE;
                end else if (r_retry_cnt == c_RETRY_LAST) begin
                    w_drop       = 1'b1;
                    w_next_state = c_S_IDLE;
                end else begin
                    // Slip a pending read in between retries so a full queue can drain.
                    w_retry_inc  = 1'b1;
                    w_next_state = (r_rd_pend && w_q_nonempty) ? c_S_DEQ : c_S_ENQ;
                end
            end
            c_S_DEQ: begin
                w_next_state = c_S_DEQ_WAIT;
            end
            c_S_DEQ_WAIT: begin
                w_rd_done    = 1'b1;
                w_next_state = r_wr_held ? c_S_ENQ : c_S_IDLE;
            end
            default: begin
                w_next_state = c_S_IDLE;
            end
        endcase
    end

    // Held write byte, its retry counter and completion pulses.
    always_ff @(posedge clk_10khz) begin
        if (reset) begin
            r_wr_held   <= 1'b0;
            r_retry_cnt <= '0;
            r_q_data    <= '0;
            r_wr_done   <= 1'b0;
            r_wr_err    <= 1'b0;
        end else begin
            r_wr_done <= w_ack_done;
            r_wr_err  <= w_drop;
            if (w_capture) begin
                r_q_data    <= wr_data;
                r_wr_held   <= 1'b1;
                r_retry_cnt <= '0;
            end else begin
                if (w_ack_done || w_drop) begin
                    r_wr_held <= 1'b0;
                end
                if (w_retry_inc) begin
                    r_retry_cnt <= r_retry_cnt + c_RETRY_W'(1);
                end
            end
        end
    end

    // Read request latch, returned byte and read-side pulses; service clears win over new pulses.
    always_ff @(posedge clk_10khz) begin
        if (reset) begin
            r_rd_pend      <= 1'b0;
            r_rd_data      <= '0;
            r_rd_valid     <= 1'b0;
            r_rd_empty_err <= 1'b0;
        end else begin
            r_rd_valid     <= w_rd_done;
            r_rd_empty_err <= w_empty_err;
            if (w_rd_done) begin
                r_rd_data <= q_data_out;
            end
            if (w_rd_done || w_empty_err) begin
                r_rd_pend <= 1'b0;
            end else if (rd_req) begin
                r_rd_pend <= 1'b1;
            end
        end
    end

    assign wr_ready     = (r_state == c_S_IDLE) && !r_wr_held && !r_rd_pend && !reset;
    assign wr_done      = r_wr_done;
    assign wr_err       = r_wr_err;
    assign rd_valid     = r_rd_valid;
    assign rd_data      = r_rd_data;
    assign rd_empty_err = r_rd_empty_err;
    assign q_data       = r_q_data;
    assign q_enqueue    = (r_state == c_S_ENQ);
    assign q_dequeue    = (r_state == c_S_DEQ);
    assign busy         = (r_state != c_S_IDLE) || r_rd_pend || r_wr_held;

endmodule
`default_nettype wire

// File: tb/tb_queue_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_queue_controller                                           |
// | Brief    : Directed self-checking bench for queue_controller with a      |
// |            small behavioural 8-entry queue (registered ack/data_out).    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_queue_controller;

    logic       clk_10khz = 1'b0;
    logic       reset     = 1'b1;
    logic       wr_valid  = 1'b0;
    logic [7:0] wr_data   = 8'h00;
    logic       wr_ready;
    logic       wr_done;
    logic       wr_err;
    logic       rd_req    = 1'b0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_empty_err;
    logic [7:0] q_data;
    logic       q_enqueue;
    logic       q_dequeue;
    logic       q_ack      = 1'b0;
    logic [3:0] q_len;
    logic [7:0] q_data_out = 8'h00;
    logic       busy;

    int passed = 0;
    int total  = 0;

    queue_controller #(
        .DATA_W   (8),
        .DEPTH    (8),
        .MAX_RETRY(4)
    ) dut (
        .clk_10khz   (clk_10khz),
        .reset       (reset),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .wr_done     (wr_done),
        .wr_err      (wr_err),
        .rd_req      (rd_req),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_empty_err(rd_empty_err),
        .q_data      (q_data),
        .q_enqueue   (q_enqueue),
        .q_dequeue   (q_dequeue),
        .q_ack       (q_ack),
        .q_len       (q_len),
        .q_data_out  (q_data_out),
        .busy        (busy)
    );

    always #50 clk_10khz = ~clk_10khz;

    // Behavioural queue: preloadable with bytes 0x10,0x11,...; ack and data_out registered.
    logic [7:0] mem [0:7];
    int         head    = 0;
    int         cnt     = 0;
    logic       load_go = 1'b0;
    int         load_n  = 0;

    assign q_len = 4'(cnt);

    always @(posedge clk_10khz) begin
        q_ack <= 1'b0;
        if (load_go) begin
            for (int i = 0; i < 8; i++) mem[i] <= 8'(8'h10 + i);
            head <= 0;
            cnt  <= load_n;
        end else if (q_enqueue) begin
            if (cnt < 8) begin
                mem[(head + cnt) % 8] <= q_data;
                cnt   <= cnt + 1;
                q_ack <= 1'b1;
            end
        end else if (q_dequeue) begin
            if (cnt > 0) begin
                q_data_out <= mem[head];
                head       <= (head + 1) % 8;
                cnt        <= cnt - 1;
            end
        end
    end

    // Pulse monitor: running counts and an ordered log of enqueue/dequeue events.
    int  enq_n = 0, deq_n = 0, done_n = 0, err_n = 0, rv_n = 0, empty_n = 0, both_n = 0;
    byte ev_log[$];

    always @(negedge clk_10khz) begin
        if (q_enqueue) begin enq_n++; ev_log.push_back("E"); end
        if (q_dequeue) begin deq_n++; ev_log.push_back("D"); end
        if (q_enqueue && q_dequeue) both_n++;
        if (wr_done) done_n++;
        if (wr_err) err_n++;
        if (rd_valid) rv_n++;
        if (rd_empty_err) empty_n++;
    end

    task automatic step();
        @(posedge clk_10khz);
        #1;
    endtask

    task automatic load_queue(input int n);
        load_n  = n;
        load_go = 1'b1;
        step();
        load_go = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        @(negedge clk_10khz);
        total++; if (wr_ready !== 1'b0) $display("FAIL reset_wr_ready: got %b want 0", wr_ready); else passed++;
        total++; if ({q_enqueue, q_dequeue, busy, wr_done, wr_err, rd_valid, rd_empty_err} !== 7'b0)
            $display("FAIL reset_ctrl_outs: got %b want 0000000",
                     {q_enqueue, q_dequeue, busy, wr_done, wr_err, rd_valid, rd_empty_err}); else passed++;
        total++; if ({q_data, rd_data} !== 16'h0000) $display("FAIL reset_data_outs: got %h want 0000", {q_data, rd_data}); else passed++;
        @(posedge clk_10khz); #1;
        reset = 1'b0;
        @(negedge clk_10khz);
        total++; if (wr_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", wr_ready); else passed++;
    endtask

    task automatic test_write();
        int e0, d0;
        load_queue(0);
        e0 = enq_n; d0 = done_n;
        wr_valid = 1'b1; wr_data = 8'hA5;
        @(negedge clk_10khz);
        total++; if (wr_ready !== 1'b1) $display("FAIL wr_accept_ready: got %b want 1", wr_ready); else passed++;
        step();
        wr_valid = 1'b0;
        @(negedge clk_10khz);
        total++; if (q_enqueue !== 1'b1) $display("FAIL wr_enq_latency: got %b want 1", q_enqueue); else passed++;
        total++; if (q_data !== 8'hA5) $display("FAIL wr_q_data: got %h want a5", q_data); else passed++;
        total++; if (wr_ready !== 1'b0) $display("FAIL wr_ready_held: got %b want 0", wr_ready); else passed++;
        step();
        @(negedge clk_10khz);
        total++; if ({q_enqueue, wr_done} !== 2'b00) $display("FAIL wr_enq_wait: got %b want 00", {q_enqueue, wr_done}); else passed++;
        step();
        @(negedge clk_10khz);
        total++; if (wr_done !== 1'b1) $display("FAIL wr_done_latency: got %b want 1", wr_done); else passed++;
        total++; if (wr_ready !== 1'b1) $display("FAIL wr_ready_back: got %b want 1", wr_ready); else passed++;
        step(); step();
        total++; if (enq_n - e0 !== 1) $display("FAIL wr_enq_count: got %0d want 1", enq_n - e0); else passed++;
        total++; if (done_n - d0 !== 1) $display("FAIL wr_done_count: got %0d want 1", done_n - d0); else passed++;
    endtask

    task automatic test_read();
        int d0;
        load_queue(3);
        d0 = deq_n;
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        @(negedge clk_10khz);
        total++; if ({busy, wr_ready, q_dequeue} !== 3'b100) $display("FAIL rd_pending: got %b want 100", {busy, wr_ready, q_dequeue}); else passed++;
        step();
        @(negedge clk_10khz);
        total++; if (q_dequeue !== 1'b1) $display("FAIL rd_deq_pulse: got %b want 1", q_dequeue); else passed++;
        step();
        @(negedge clk_10khz);
        total++; if ({q_dequeue, rd_valid} !== 2'b00) $display("FAIL rd_deq_wait: got %b want 00", {q_dequeue, rd_valid}); else passed++;
        step();
        @(negedge clk_10khz);
        total++; if (rd_valid !== 1'b1) $display("FAIL rd_valid_latency: got %b want 1", rd_valid); else passed++;
        total++; if (rd_data !== 8'h10) $display("FAIL rd_data: got %h want 10", rd_data); else passed++;
        step();
        @(negedge clk_10khz);
        total++; if ({rd_valid, busy, rd_data} !== {2'b00, 8'h10}) $display("FAIL rd_after: got %b_%b_%h want 0_0_10", rd_valid, busy, rd_data); else passed++;
        total++; if (deq_n - d0 !== 1) $display("FAIL rd_deq_count: got %0d want 1", deq_n - d0); else passed++;
    endtask

    task automatic test_empty_read();
        int d0, m0;
        load_queue(0);
        d0 = deq_n; m0 = empty_n;
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        @(negedge clk_10khz);
        total++; if (rd_empty_err !== 1'b0) $display("FAIL empty_early: got %b want 0", rd_empty_err); else passed++;
        step();
        @(negedge clk_10khz);
        total++; if (rd_empty_err !== 1'b1) $display("FAIL empty_pulse: got %b want 1", rd_empty_err); else passed++;
        total++; if ({busy, wr_ready} !== 2'b01) $display("FAIL empty_pend_clear: got %b want 01", {busy, wr_ready}); else passed++;
        step(); step();
        total++; if (empty_n - m0 !== 1) $display("FAIL empty_count: got %0d want 1", empty_n - m0); else passed++;
        total++; if (deq_n - d0 !== 0) $display("FAIL empty_no_deq: got %0d want 0", deq_n - d0); else passed++;
    endtask

    task automatic test_full_retry();
        int e0, d0, r0;
        int bad_qdata;
        load_queue(8);
        e0 = enq_n; d0 = done_n; r0 = err_n; bad_qdata = 0;
        wr_valid = 1'b1; wr_data = 8'h3C;
        step();
        wr_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_10khz);
            if (q_enqueue && q_data != 8'h3C) bad_qdata++;
            step();
        end
        total++; if (enq_n - e0 !== 4) $display("FAIL full_enq_count: got %0d want 4", enq_n - e0); else passed++;
        total++; if (err_n - r0 !== 1) $display("FAIL full_err_count: got %0d want 1", err_n - r0); else passed++;
        total++; if (done_n - d0 !== 0) $display("FAIL full_no_done: got %0d want 0", done_n - d0); else passed++;
        total++; if (bad_qdata !== 0) $display("FAIL full_q_data_stable: got %0d bad cycles want 0", bad_qdata); else passed++;
        total++; if ({busy, wr_ready} !== 2'b01) $display("FAIL full_idle_after: got %b want 01", {busy, wr_ready}); else passed++;
    endtask

    task automatic test_back_to_back();
        int e0, d0, dn0, r0, v0, b0, base;
        string seq;
        load_queue(8);
        e0 = enq_n; d0 = deq_n; dn0 = done_n; r0 = err_n; v0 = rv_n; b0 = both_n;
        base = ev_log.size();
        wr_valid = 1'b1; wr_data = 8'h77;
        step();
        wr_valid = 1'b0;
        rd_req   = 1'b1;
        step();
        rd_req   = 1'b0;
        for (int i = 0; i < 12; i++) step();
        seq = "";
        for (int i = base; i < ev_log.size(); i++) seq = {seq, string'(ev_log[i])};
        total++; if (seq != "EDE") $display("FAIL b2b_sequence: got %s want EDE", seq); else passed++;
        total++; if ({enq_n - e0, deq_n - d0} !== {32'd2, 32'd1}) $display("FAIL b2b_counts: got enq=%0d deq=%0d want enq=2 deq=1", enq_n - e0, deq_n - d0); else passed++;
        total++; if ({done_n - dn0, rv_n - v0, err_n - r0} !== {32'd1, 32'd1, 32'd0}) $display("FAIL b2b_pulses: got done=%0d rv=%0d err=%0d want 1 1 0", done_n - dn0, rv_n - v0, err_n - r0); else passed++;
        total++; if (both_n - b0 !== 0) $display("FAIL b2b_overlap: got %0d want 0", both_n - b0); else passed++;
        total++; if (rd_data !== 8'h10) $display("FAIL b2b_rd_data: got %h want 10", rd_data); else passed++;
        total++; if (cnt !== 8) $display("FAIL b2b_queue_len: got %0d want 8", cnt); else passed++;
    endtask

    task automatic test_reset_mid();
        int dn0, r0;
        load_queue(8);
        wr_valid = 1'b1; wr_data = 8'h5A;
        step();
        wr_valid = 1'b0;
        step();
        @(negedge clk_10khz);
        total++; if ({busy, q_enqueue, q_data} !== {2'b10, 8'h5A}) $display("FAIL rmid_in_wait: got %b_%b_%h want 1_0_5a", busy, q_enqueue, q_data); else passed++;
        dn0 = done_n; r0 = err_n;
        @(posedge clk_10khz); #1;
        reset = 1'b1;
        step();
        @(negedge clk_10khz);
        total++; if ({q_enqueue, q_dequeue, busy, wr_ready, wr_done, wr_err, rd_valid, rd_empty_err} !== 8'b0)
            $display("FAIL rmid_ctrl_outs: got %b want 00000000",
                     {q_enqueue, q_dequeue, busy, wr_ready, wr_done, wr_err, rd_valid, rd_empty_err}); else passed++;
        total++; if ({q_data, rd_data} !== 16'h0000) $display("FAIL rmid_data_outs: got %h want 0000", {q_data, rd_data}); else passed++;
        @(posedge clk_10khz); #1;
        reset = 1'b0;
        @(negedge clk_10khz);
        total++; if ({wr_ready, busy} !== 2'b10) $display("FAIL rmid_ready_after: got %b want 10", {wr_ready, busy}); else passed++;
        for (int i = 0; i < 6; i++) step();
        total++; if ({done_n - dn0, err_n - r0} !== {32'd0, 32'd0}) $display("FAIL rmid_no_pulses: got done=%0d err=%0d want 0 0", done_n - dn0, err_n - r0); else passed++;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_empty_read();
        test_full_retry();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/queue_controller.md
Name: queue_controller

Overview:
- Initiator-side controller for the 8-entry byte queue used in the clk_10khz domain.
- Accepts bytes from an upstream producer over a valid/ready handshake and issues single-cycle enqueue pulses to the queue. Checks the queue's registered ack and retries on rejection.
- Services read requests by issuing single-cycle dequeue pulses and returning the captured byte with a one-cycle valid strobe.
- Never asserts enqueue and dequeue in the same cycle.

Parameters:
DATA_W, 8, byte width of queue data.
DEPTH, 8, queue capacity; q_len == DEPTH means full.
MAX_RETRY, 4, enqueue attempts per byte before the byte is dropped (>=1).

Ports:
clk_10khz  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high
wr_valid  in  1  producer has byte on wr_data
wr_data  in  DATA_W  producer byte
wr_ready  out  1  controller can accept a byte this cycle
wr_done  out  1  1-cycle pulse: held byte acked by queue
wr_err  out  1  1-cycle pulse: held byte dropped after MAX_RETRY nacks
rd_req  in  1  read request pulse, latched internally
rd_valid  out  1  1-cycle pulse: rd_data valid
rd_data  out  DATA_W  byte returned from queue, held until next rd_valid
rd_empty_err  out  1  1-cycle pulse: read requested while q_len == 0
q_data  out  DATA_W  to queue data_in
q_enqueue  out  1  to queue enqueue_in
q_dequeue  out  1  to queue dequeue_in
q_ack  in  1  from queue ack_in (registered by queue)
q_len  in  4  from queue len_out
q_data_out  in  DATA_W  from queue data_out (registered by queue)
busy  out  1  state != IDLE or rd_pend or wr_held

Behaviour:
- Reset (synchronous, any state, any time): state=IDLE. rd_pend, wr_held, retry_cnt cleared. All outputs 0, including rd_data, q_data and wr_ready. A byte held mid-operation is discarded with no wr_err.
- rd_req: sets rd_pend on any cycle; cleared when serviced. Multiple pulses while pending merge into one request.
- FSM states: IDLE, ENQ, ENQ_WAIT, DEQ, DEQ_WAIT. q_enqueue=1 only in ENQ; q_dequeue=1 only in DEQ (Moore decode).
- wr_ready = (state==IDLE) && !wr_held && !rd_pend && !reset.
- IDLE, priority order:
  - rd_pend && q_len>0 -> DEQ.
  - rd_pend && q_len==0 -> rd_empty_err pulse next cycle, clear rd_pend, stay IDLE.
  - wr_valid && wr_ready -> capture wr_data into q_data, set wr_held, retry_cnt=0, -> ENQ.
- ENQ: q_enqueue high exactly one cycle -> ENQ_WAIT.
- ENQ_WAIT: sample q_ack.
  - q_ack=1: clear wr_held, wr_done pulse, -> IDLE.
  - q_ack=0, retry_cnt==MAX_RETRY-1: clear wr_held, wr_err pulse, -> IDLE.
  - q_ack=0 otherwise: retry_cnt+1. If rd_pend && q_len>0 -> DEQ (byte stays held); else -> ENQ.
- DEQ: q_dequeue high exactly one cycle -> DEQ_WAIT.
- DEQ_WAIT: rd_data <= q_data_out, rd_valid pulse, clear rd_pend. Next state is ENQ if wr_held, else IDLE.
- Latency:
  - Write accept to q_enqueue: 1 cycle.
  - Enqueue to wr_done: 2 cycles on first-try ack.
  - IDLE with rd_pend to rd_valid: 3 cycles.
- q_data is stable from capture until wr_held clears. retry_cnt width is clog2(MAX_RETRY)+1 and never wraps.
- Full queue: enqueue is still issued; the nack consumes a retry. A pending read is interleaved between retries so a full queue can drain.

Test Plan:
- Reset, then write 0xA5 with q_ack stubbed 1 cycle after q_enqueue -> one q_enqueue pulse, q_data=0xA5, wr_done 2 cycles later, wr_ready back to 1.
- Queue model loaded with 3 bytes, pulse rd_req -> one q_dequeue pulse, rd_valid 3 cycles after rd_req latch, rd_data = model output.
- rd_req with q_len=0 -> rd_empty_err single pulse, no q_dequeue, rd_pend cleared.
- Queue full (q_len=8), write 0x3C, no reads, MAX_RETRY=4 -> exactly 4 q_enqueue pulses, then wr_err pulse; wr_done never asserted.
- Queue full, write 0x77, rd_req after first nack -> sequence ENQ, DEQ, ENQ; second enqueue acked; wr_done and rd_valid each pulse once; q_enqueue and q_dequeue never high together.
- Assert reset in ENQ_WAIT with byte held -> next cycle all outputs 0, state IDLE, no wr_err/wr_done, wr_ready=1 after reset deasserts.
